alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
- Parametrised successor to the single-cycle datapath ALU.
- Keeps the combinational AND/OR/ADD/SUB/SLT/NOR ops at WIDTH bits.
- Adds an iterative unsigned multiply/divide unit with HI/LO result registers and a start/busy/done handshake.
- Sits in the EX stage; control stalls the pipeline while busy=1 and reads results via MFHI/MFLO opcodes.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not to be overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- data1  input  WIDTH  rs operand; dividend / multiplicand.
- data2  input  WIDTH  rt operand or immediate; divisor / multiplier.
- ALU_control  input  4  operation select.
- start  input  1  launch a multicycle op when ALU_control is MULTU or DIVU.
- result  output  WIDTH  combinational result.
- zero  output  1  (result == 0).
- busy  output  1  multicycle op in progress.
- done  output  1  one-cycle pulse when HI/LO are updated.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, rst=1): hi=0, lo=0, busy=0, done=0, counter=0, FSM=IDLE. result and zero stay combinational.
- Combinational opcodes (result valid in the same cycle, independent of busy):
  - 0 AND, 1 OR, 2 ADD (mod 2^WIDTH), 6 SUB (mod 2^WIDTH), 12 NOR.
  - 7 SLT: signed compare, result=1 if $signed(data1)<$signed(data2), else 0.
  - 8 SLTU: unsigned compare.
  - 13 MFHI: result=hi. 14 MFLO: result=lo.
  - All other codes, including 4 and 5: result=0.
- Multicycle opcodes: 4 MULTU, 5 DIVU.
- FSM states IDLE, RUN, DONE:
  - IDLE -> RUN when start=1 and ALU_control is 4 or 5. Operands and op are latched that cycle; busy=1 from the next cycle.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle for exactly WIDTH cycles.
  - RUN -> DONE after WIDTH steps. On the DONE cycle hi/lo hold the final values, done=1, busy=0.
  - DONE -> IDLE unconditionally.
- Latency: start accepted at edge N; done=1 during cycle N+WIDTH+1.
- start with any other opcode: ignored. start while busy or in DONE: ignored, with no re-latch.
- MULTU: {hi,lo} = data1*data2 (2*WIDTH-bit unsigned product).
- DIVU: lo=quotient, hi=remainder.
- DIVU by zero: lo=all ones, hi=data1 (latched value). Same latency, no exception.
- hi/lo change only on the DONE transition or reset. During RUN, MFHI/MFLO return the old values.
- rst asserted mid-operation: aborts immediately, all state cleared, no done pulse.
- Inputs changing during RUN have no effect (operands are latched).

Optional Feature:
- Macro SIGNED_MULDIV_EN.
- When defined: adds opcodes 10 MULT and 11 DIV (signed).
  - Operands are converted to magnitudes, the unsigned engine is run, and results are negated at DONE.
  - Same latency as the unsigned ops.
  - Quotient sign = sign(data1) XOR sign(data2); remainder sign = sign(data1).
  - DIV by zero: lo=all ones, hi=data1.
  - Most-negative / -1: lo=most-negative, hi=0.
- When undefined: codes 10/11 behave as unused (result=0, start ignored). No sign logic is synthesised.

Decomposition:
- Package alu_pkg: localparam opcode constants (OP_AND..OP_MFLO, OP_MULT, OP_DIV) and the FSM state enum.
- Sub-module muldiv_unit: owns the FSM, counter, operand latches and HI/LO. alu_muldiv instantiates it alongside the combinational op mux.

Test Plan:
- Combinational sweep, WIDTH=32: ADD 0xFFFFFFFF+1 -> result 0, zero=1. SLT -1 vs 1 -> 1. SLTU same operands -> 0. NOR 0,0 -> 0xFFFFFFFF.
- MULTU 0xFFFFFFFF*0xFFFFFFFF with start at cycle 0 -> done at cycle 33, hi=0xFFFFFFFE, lo=0x00000001. busy=1 for cycles 1..32. MFHI/MFLO then return these values.
- DIVU 100/7 -> lo=14, hi=2. DIVU 5/0 -> lo=0xFFFFFFFF, hi=5. Both with a 33-cycle done.
- start re-asserted with different operands mid-RUN -> ignored; result matches the first op. Old hi/lo remain readable until done.
- rst pulse at cycle 10 of a MULTU -> busy=0, hi=lo=0 immediately. No done pulse. A new start afterwards completes normally.
- With SIGNED_MULDIV_EN: DIV -7/2 -> lo=-3, hi=-1. MULT -3*4 -> {hi,lo} = -12 sign-extended. Without the macro: start with opcode 10 -> busy stays 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode constants and multiply/divide FSM state for the EX-stage ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Optional macro SIGNED_MULDIV_EN enables OP_MULT/OP_DIV in the RTL; the
// constants are always declared so decoders can name them.
package alu_pkg;

   localparam logic [3:0] OP_AND   = 4'd0;
   localparam logic [3:0] OP_OR    = 4'd1;
   localparam logic [3:0] OP_ADD   = 4'd2;
   localparam logic [3:0] OP_MULTU = 4'd4;
   localparam logic [3:0] OP_DIVU  = 4'd5;
   localparam logic [3:0] OP_SUB   = 4'd6;
   localparam logic [3:0] OP_SLT   = 4'd7;
   localparam logic [3:0] OP_SLTU  = 4'd8;
   localparam logic [3:0] OP_MULT  = 4'd10;
   localparam logic [3:0] OP_DIV   = 4'd11;
   localparam logic [3:0] OP_NOR   = 4'd12;
   localparam logic [3:0] OP_MFHI  = 4'd13;
   localparam logic [3:0] OP_MFLO  = 4'd14;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } md_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine owning the FSM, iteration counter, operand latches and HI/LO.
// Latency: start accepted at edge N, done pulses (HI/LO valid) during cycle N+WIDTH+1.
// Backpressure: none; start is ignored unless IDLE, caller stalls on busy.
// Ports: clk/rst (async active-high), data1/data2 operands, op select, start;
//        busy, done (one-cycle pulse), hi, lo result registers.
// SIGNED_MULDIV_EN: adds signed MULT/DIV via magnitude conversion and result negation.
module muldiv_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   input  logic [3:0]       op,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   md_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic             is_div;
   logic [WIDTH-1:0] m_reg;   // multiplicand, or divisor
   logic [WIDTH-1:0] acc;     // running product high half, or partial remainder
   logic [WIDTH-1:0] q_reg;   // multiplier shifting out / product low half, or dividend / quotient

   logic             op_mul, op_div, launch;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH+1:0] div_diff;
   logic [WIDTH-1:0] acc_nxt, q_nxt;
   logic [WIDTH-1:0] hi_fin, lo_fin;

`ifdef SIGNED_MULDIV_EN
   logic             op_signed;
   logic             neg_q;     // negate quotient, or whole product for MULT
   logic             neg_r;     // negate remainder
   logic [2*WIDTH-1:0] prod_neg;
`endif

   // Opcode decode and operand magnitudes
   always_comb begin
      op_mul = (op == OP_MULTU);
      op_div = (op == OP_DIVU);
      a_mag  = data1;
      b_mag  = data2;
`ifdef SIGNED_MULDIV_EN
      op_signed = (op == OP_MULT) || (op == OP_DIV);
      if (op == OP_MULT) op_mul = 1'b1;
      if (op == OP_DIV)  op_div = 1'b1;
      if (op_signed && data1[WIDTH-1]) a_mag = -data1;
      if (op_signed && data2[WIDTH-1]) b_mag = -data2;
`endif
   end

   assign launch = (state == ST_IDLE) && start && (op_mul || op_div);

   // One iteration of either engine.
   // Multiply: conditional add of the multiplicand, then shift {acc,q} right.
   // Divide: shift {acc,q} left one bit, trial-subtract the divisor, keep it if no borrow.
   // With a zero divisor every trial succeeds, so the quotient fills with ones and the
   // remainder ends up as the dividend itself, which is exactly the required by-zero result.
   always_comb begin
      mul_sum   = {1'b0, acc} + (q_reg[0] ? {1'b0, m_reg} : '0);
      div_shift = {acc, q_reg[WIDTH-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, m_reg};
      if (is_div) begin
         if (!div_diff[WIDTH+1]) begin
            acc_nxt = div_diff[WIDTH-1:0];
            q_nxt   = {q_reg[WIDTH-2:0], 1'b1};
         end else begin
            acc_nxt = div_shift[WIDTH-1:0];
            q_nxt   = {q_reg[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_nxt = mul_sum[WIDTH:1];
         q_nxt   = {mul_sum[0], q_reg[WIDTH-1:1]};
      end
   end

   // Final HI/LO values written on the last RUN step
   always_comb begin
      hi_fin = acc_nxt;
      lo_fin = q_nxt;
`ifdef SIGNED_MULDIV_EN
      prod_neg = -{acc_nxt, q_nxt};
      if (!is_div && neg_q) begin
         hi_fin = prod_neg[2*WIDTH-1:WIDTH];
         lo_fin = prod_neg[WIDTH-1:0];
      end
      if (is_div && neg_q) lo_fin = -q_nxt;
      if (is_div && neg_r) hi_fin = -acc_nxt;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         is_div <= 1'b0;
         m_reg  <= '0;
         acc    <= '0;
         q_reg  <= '0;
`ifdef SIGNED_MULDIV_EN
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (launch) begin
                  state  <= ST_RUN;
                  busy   <= 1'b1;
                  cnt    <= '0;
                  is_div <= op_div;
                  acc    <= '0;
                  m_reg  <= op_div ? b_mag : a_mag;
                  q_reg  <= op_div ? a_mag : b_mag;
`ifdef SIGNED_MULDIV_EN
                  // A zero divisor keeps the all-ones quotient unnegated
                  neg_q  <= op_signed && (data1[WIDTH-1] ^ data2[WIDTH-1]) &&
                            (!op_div || (data2 != '0));
                  neg_r  <= op_signed && op_div && data1[WIDTH-1];
`endif
               end
            end
            ST_RUN: begin
               acc   <= acc_nxt;
               q_reg <= q_nxt;
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  hi    <= hi_fin;
                  lo    <= lo_fin;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage ALU: single-cycle logic/arith/compare ops plus an iterative HI/LO multiply/divide unit.
// Latency: result/zero combinational; MULTU/DIVU done pulse WIDTH+1 cycles after the start edge.
// Backpressure: busy high while the multicycle unit runs; control must stall, extra starts are dropped.
// Ports: clk, rst (async active-high), data1/data2 operands, ALU_control opcode, start;
//        result, zero, busy, done, hi, lo.
// SIGNED_MULDIV_EN: adds signed MULT (10) and DIV (11); undefined means those codes are unused.
module alu_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   input  logic [3:0]       ALU_control,
   input  logic             start,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   muldiv_unit #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_muldiv (
      .clk   (clk),
      .rst   (rst),
      .data1 (data1),
      .data2 (data2),
      .op    (ALU_control),
      .start (start),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   // Multicycle opcodes and unused codes fall to the default and read as zero
   always_comb begin
      result = '0;
      case (ALU_control)
         OP_AND:  result = data1 & data2;
         OP_OR:   result = data1 | data2;
         OP_ADD:  result = data1 + data2;
         OP_SUB:  result = data1 - data2;
         OP_SLT:  result = WIDTH'($signed(data1) < $signed(data2));
         OP_SLTU: result = WIDTH'(data1 < data2);
         OP_NOR:  result = ~(data1 | data2);
         OP_MFHI: result = hi;
         OP_MFLO: result = lo;
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] data1, data2;
   logic [3:0]   ALU_control;
   logic         start;
   logic [W-1:0] result, hi, lo;
   logic         zero, busy, done;

   always #5 clk = ~clk;

   alu_muldiv #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .data1(data1), .data2(data2),
      .ALU_control(ALU_control), .start(start),
      .result(result), .zero(zero), .busy(busy), .done(done),
      .hi(hi), .lo(lo)
   );

   int total = 0;
   int bad   = 0;

   // Reference HI/LO as the architecture defines them
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_res;
      logic         exp_zero;
   } vec_t;
   vec_t vecs[$];

   function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, b, r, input logic z);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.exp_res = r; v.exp_zero = z;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_comb(input logic [3:0] op, input logic [W-1:0] a, b);
      longint unsigned ua = {32'b0, a};
      longint unsigned ub = {32'b0, b};
      case (op)
         4'd0:  return a & b;
         4'd1:  return a | b;
         4'd2:  return W'(ua + ub);
         4'd6:  return W'(ua - ub);
         4'd7:  return (int'(a) < int'(b)) ? 1 : 0;
         4'd8:  return (ua < ub) ? 1 : 0;
         4'd12: return ~(a | b);
         4'd13: return m_hi;
         4'd14: return m_lo;
         default: return '0;
      endcase
   endfunction

   task automatic ref_md(input logic [3:0] op, input logic [W-1:0] a, b);
      longint unsigned p;
      longint          sp;
      int              sa, sb;
      sa = int'(a);
      sb = int'(b);
      case (op)
         4'd4: begin
            p = {32'b0, a} * {32'b0, b};
            {m_hi, m_lo} = p;
         end
         4'd5: begin
            if (b == 0) begin m_lo = '1; m_hi = a; end
            else begin m_lo = a / b; m_hi = a % b; end
         end
`ifdef SIGNED_MULDIV_EN
         4'd10: begin
            sp = longint'(sa) * longint'(sb);
            {m_hi, m_lo} = sp;
         end
         4'd11: begin
            if (sb == 0) begin m_lo = '1; m_hi = a; end
            else if (a == 32'h8000_0000 && sb == -1) begin m_lo = a; m_hi = '0; end
            else begin m_lo = sa / sb; m_hi = sa % sb; end
         end
`endif
         default: begin
            sp = longint'(sa) + longint'(sb);
         end
      endcase
   endtask

   // Launch one multicycle op, scramble inputs while it runs, check timing and HI/LO
   task automatic run_md(input string name, input logic [3:0] op, input logic [W-1:0] a, b);
      int lat, bn;
      ALU_control = op; data1 = a; data2 = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      data1 = $urandom; data2 = $urandom;
      ALU_control = 4'd13;
      #1 chk({name, " old_hi_during_run"}, result, m_hi);
      ALU_control = 4'd14;
      #1 chk({name, " old_lo_during_run"}, result, m_lo);
      lat = 0; bn = 0;
      while (!done && lat < 40) begin
         if (busy) bn++;
         @(posedge clk); #1;
         lat++;
      end
      ref_md(op, a, b);
      chk({name, " latency"}, lat, W);
      chk({name, " busy_cycles"}, bn, W);
      chk({name, " busy_on_done"}, busy, 1'b0);
      chk({name, " hi"}, hi, m_hi);
      chk({name, " lo"}, lo, m_lo);
      @(posedge clk); #1;
      chk({name, " done_one_cycle"}, done, 1'b0);
   endtask

   initial begin
      int lat, seen;
      logic [3:0] op;
      logic [W-1:0] a, b;

      rst = 1'b1; start = 1'b0; ALU_control = 4'd0; data1 = '0; data2 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", busy, 1'b0);
      chk("reset done", done, 1'b0);
      chk("reset hi", hi, '0);
      chk("reset lo", lo, '0);
      rst = 1'b0;

      // Directed combinational vectors
      vecs.push_back(mk(4'd2,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1));
      vecs.push_back(mk(4'd7,  32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0));
      vecs.push_back(mk(4'd7,  32'h1,         32'hFFFF_FFFF, 32'h0,         1'b1));
      vecs.push_back(mk(4'd8,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1));
      vecs.push_back(mk(4'd8,  32'h1,         32'hFFFF_FFFF, 32'h1,         1'b0));
      vecs.push_back(mk(4'd12, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0));
      vecs.push_back(mk(4'd0,  32'hF0F0_1234, 32'hFF00_00FF, 32'hF000_0034, 1'b0));
      vecs.push_back(mk(4'd1,  32'hF0F0_0000, 32'h0000_1234, 32'hF0F0_1234, 1'b0));
      vecs.push_back(mk(4'd6,  32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0));
      vecs.push_back(mk(4'd6,  32'h1234,      32'h1234,      32'h0,         1'b1));
      vecs.push_back(mk(4'd4,  32'h5,         32'h7,         32'h0,         1'b1));
      vecs.push_back(mk(4'd5,  32'h5,         32'h7,         32'h0,         1'b1));
      vecs.push_back(mk(4'd3,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b1));
      vecs.push_back(mk(4'd10, 32'h5,         32'h7,         32'h0,         1'b1));
      vecs.push_back(mk(4'd15, 32'h5,         32'h7,         32'h0,         1'b1));
      vecs.push_back(mk(4'd13, 32'h5,         32'h7,         32'h0,         1'b1));
      foreach (vecs[i]) begin
         ALU_control = vecs[i].op; data1 = vecs[i].a; data2 = vecs[i].b;
         #1;
         chk($sformatf("vec%0d op%0d result", i, vecs[i].op), result, vecs[i].exp_res);
         chk($sformatf("vec%0d op%0d zero", i, vecs[i].op), zero, vecs[i].exp_zero);
      end
      @(posedge clk); #1;

      // Directed multicycle cases with fixed expected values as well as the model
      run_md("multu_ff_ff", 4'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("multu_ff_ff hi const", hi, 32'hFFFF_FFFE);
      chk("multu_ff_ff lo const", lo, 32'h0000_0001);
      ALU_control = 4'd13; #1 chk("mfhi after multu", result, 32'hFFFF_FFFE);
      ALU_control = 4'd14; #1 chk("mflo after multu", result, 32'h0000_0001);
      run_md("divu_100_7", 4'd5, 32'd100, 32'd7);
      chk("divu_100_7 lo const", lo, 32'd14);
      chk("divu_100_7 hi const", hi, 32'd2);
      run_md("divu_5_0", 4'd5, 32'd5, 32'd0);
      chk("divu_5_0 lo const", lo, 32'hFFFF_FFFF);
      chk("divu_5_0 hi const", hi, 32'd5);

      // start re-asserted mid-RUN with other operands must be ignored
      ALU_control = 4'd4; data1 = 32'd3; data2 = 32'd5; start = 1'b1;
      @(posedge clk); #1;
      lat = 0;
      start = 1'b0;
      repeat (5) begin @(posedge clk); #1; lat++; end
      ALU_control = 4'd5; data1 = 32'd1000; data2 = 32'd3; start = 1'b1;
      repeat (3) begin @(posedge clk); #1; lat++; end
      start = 1'b0;
      ALU_control = 4'd13; #1 chk("midrun old hi", result, 32'd5);
      ALU_control = 4'd14; #1 chk("midrun old lo", result, 32'hFFFF_FFFF);
      while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
      chk("midrun latency", lat, W);
      chk("midrun hi", hi, 32'd0);
      chk("midrun lo", lo, 32'd15);
      m_hi = 32'd0; m_lo = 32'd15;
      repeat (3) @(posedge clk);
      #1 chk("midrun no relaunch", busy, 1'b0);

      // Reset abort during MULTU
      ALU_control = 4'd4; data1 = 32'd7; data2 = 32'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("abort busy", busy, 1'b0);
      chk("abort hi", hi, '0);
      chk("abort lo", lo, '0);
      m_hi = '0; m_lo = '0;
      @(posedge clk); #1 rst = 1'b0;
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done || busy) seen++;
      end
      chk("abort no done", seen, 0);
      run_md("after_abort_divu", 4'd5, 32'd1000, 32'd3);
      chk("after_abort lo const", lo, 32'd333);
      chk("after_abort hi const", hi, 32'd1);

      // start with a non-multicycle opcode is dropped
      ALU_control = 4'd2; data1 = 32'd1; data2 = 32'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start add ignored", busy, 1'b0);
`ifdef SIGNED_MULDIV_EN
      run_md("div_m7_2", 4'd11, 32'hFFFF_FFF9, 32'd2);
      chk("div_m7_2 lo const", lo, 32'hFFFF_FFFD);
      chk("div_m7_2 hi const", hi, 32'hFFFF_FFFF);
      run_md("mult_m3_4", 4'd10, 32'hFFFF_FFFD, 32'd4);
      chk("mult_m3_4 hi const", hi, 32'hFFFF_FFFF);
      chk("mult_m3_4 lo const", lo, 32'hFFFF_FFF4);
      run_md("div_min_m1", 4'd11, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("div_min_m1 lo const", lo, 32'h8000_0000);
      chk("div_min_m1 hi const", hi, 32'h0);
      run_md("div_m9_0", 4'd11, 32'hFFFF_FFF7, 32'd0);
      chk("div_m9_0 lo const", lo, 32'hFFFF_FFFF);
      chk("div_m9_0 hi const", hi, 32'hFFFF_FFF7);
`else
      ALU_control = 4'd10; data1 = 32'd3; data2 = 32'd4; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      seen = 0;
      repeat (3) begin if (busy) seen++; @(posedge clk); #1; end
      chk("op10 start ignored", seen, 0);
      chk("op10 hi unchanged", hi, m_hi);
`endif

      // Randomized multicycle ops against the model
      for (int i = 0; i < 24; i++) begin
`ifdef SIGNED_MULDIV_EN
         case ($urandom_range(0, 3))
            0: op = 4'd4; 1: op = 4'd5; 2: op = 4'd10; default: op = 4'd11;
         endcase
`else
         op = ($urandom_range(0, 1) == 0) ? 4'd4 : 4'd5;
`endif
         a = $urandom;
         case ($urandom_range(0, 7))
            0: b = '0;
            1, 2: b = W'($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         run_md($sformatf("rand%0d op%0d", i, op), op, a, b);
      end

      // Randomized combinational ops, including MFHI/MFLO of the model's HI/LO
      for (int i = 0; i < 120; i++) begin
         op = 4'($urandom_range(0, 15));
         a = $urandom;
         b = ($urandom_range(0, 5) == 0) ? a : $urandom;
         ALU_control = op; data1 = a; data2 = b;
         #1;
         chk($sformatf("rcomb%0d op%0d result", i, op), result, ref_comb(op, a, b));
         chk($sformatf("rcomb%0d op%0d zero", i, op), zero, ref_comb(op, a, b) == '0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
